data_mem_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle data memory. Sits between the MEM stage / load-store unit and the data array.
- Request/response valid-ready handshake, configurable read latency, and credit-based backpressure with an in-order response FIFO.
- Byte/half/word access with zero or sign extension. Misaligned and out-of-range accesses are flagged as errors instead of silently corrupting data.

---
 rtl/data_mem_pipe.sv | 182 ++++++++++++++++++
 tb/tb_data_mem_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_pipe.sv
// Pipelined data memory with valid/ready request/response, credit backpressure and in-order FIFO.
// Optional macro DM_WSTRB_EN adds req_wstrb byte strobes for word stores.
module data_mem_pipe #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned DEPTH_LOG2 = 10,  // legal range 1..29
  parameter int unsigned READ_LAT   = 2,   // legal range 1..4
  parameter int unsigned RSP_DEPTH  = READ_LAT + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_op,
  input  logic        req_ext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DM_WSTRB_EN
  input  logic [3:0]  req_wstrb,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [1:0]  MEM_BYTE = 2'b00;
  localparam logic [1:0]  MEM_HALF = 2'b01;
  localparam logic [1:0]  MEM_WORD = 2'b10;
  localparam int unsigned Words    = 2 ** DEPTH_LOG2;
  localparam int unsigned CW       = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PW       = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic [31:0]           mem_q [Words];
  rsp_t                  fifo_q [RSP_DEPTH];
  logic [CW-1:0]         credits_q, credits_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;

  logic                  accept, pop, push;
  logic [31:0]           offset, rd_word, wdata_al, ext_data;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [3:0]            be;
  logic                  err, mem_we;
  rsp_t                  s0_rsp, wr_rsp, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign req_ready = (credits_q != '0);
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = (credits_q != CW'(RSP_DEPTH));

  // Addresses below BASE_ADDR wrap to a huge offset and fail the range check.
  assign offset  = req_addr - BASE_ADDR;
  assign idx     = offset[DEPTH_LOG2+1:2];
  assign lane    = offset[1:0];
  assign rd_word = mem_q[idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    err      = 1'b0;
    be       = 4'b0000;
    wdata_al = req_wdata;
    ext_data = rd_word;
    case (req_op)
      MEM_BYTE: begin
        be       = 4'b0001 << lane;
        wdata_al = {4{req_wdata[7:0]}};
        ext_data = {{24{req_ext & rd_byte[7]}}, rd_byte};
      end
      MEM_HALF: begin
        err      = lane[0];
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{req_wdata[15:0]}};
        ext_data = {{16{req_ext & rd_half[15]}}, rd_half};
      end
      MEM_WORD: begin
        err = (lane != 2'b00);
`ifdef DM_WSTRB_EN
        be  = req_wstrb;
`else
        be  = 4'b1111;
`endif
      end
      default: err = 1'b1;
    endcase
    if (offset[31:DEPTH_LOG2+2] != '0) err = 1'b1;
  end

  assign mem_we = accept && req_we && !err && rst_n;

  // Stores commit at the accept edge; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata_al[8*b +: 8];
      end
    end
  end

  always_comb begin
    s0_rsp.err  = err;
    s0_rsp.data = (err || req_we) ? 32'h0 : ext_data;
  end

  if (READ_LAT == 1) begin : g_nopipe
    assign push   = accept;
    assign wr_rsp = s0_rsp;
  end else begin : g_pipe
    logic pipe_v_q [READ_LAT-1];
    rsp_t pipe_q   [READ_LAT-1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < READ_LAT - 1; i++) begin
          pipe_v_q[i] <= 1'b0;
          pipe_q[i]   <= '0;
        end
      end else begin
        pipe_v_q[0] <= accept;
        pipe_q[0]   <= s0_rsp;
        for (int unsigned i = 1; i < READ_LAT - 1; i++) begin
          pipe_v_q[i] <= pipe_v_q[i-1];
          pipe_q[i]   <= pipe_q[i-1];
        end
      end
    end

    assign push   = pipe_v_q[READ_LAT-2];
    assign wr_rsp = pipe_q[READ_LAT-2];
  end

  always_comb begin
    credits_d = credits_q;
    if (accept && !pop)      credits_d = credits_q - CW'(1);
    else if (pop && !accept) credits_d = credits_q + CW'(1);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credits_q <= CW'(RSP_DEPTH);
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      credits_q <= credits_d;
      cnt_q     <= cnt_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Credits guarantee a free slot for every push, so no full check is needed.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= wr_rsp;
  end

  assign head      = fifo_q[rd_ptr_q];
  assign rsp_valid = (cnt_q != '0);
  assign rsp_rdata = rsp_valid ? head.data : 32'h0;
  assign rsp_err   = rsp_valid & head.err;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Self-checking bench for data_mem_pipe: vector table plus backpressure and reset sequences,
// with a response scoreboard fed at accept time.
module tb_data_mem_pipe;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int unsigned LAT  = 2;
  localparam logic [1:0]  OP_B = 2'b00;
  localparam logic [1:0]  OP_H = 2'b01;
  localparam logic [1:0]  OP_W = 2'b10;
  localparam logic [1:0]  OP_R = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_op = OP_W;
  logic        req_ext = 1'b0;
  logic [31:0] req_addr = BASE;
  logic [31:0] req_wdata = 32'h0;
`ifdef DM_WSTRB_EN
  logic [3:0]  req_wstrb = 4'hF;
`endif
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  always #5 clk = ~clk;

  data_mem_pipe #(
    .BASE_ADDR (BASE),
    .DEPTH_LOG2(10),
    .READ_LAT  (LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_op   (req_op),
    .req_ext  (req_ext),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
`ifdef DM_WSTRB_EN
    .req_wstrb(req_wstrb),
`endif
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  typedef struct {
    logic        we;
    logic [1:0]  op;
    logic        ext;
    logic [31:0] off;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  vec_t bp[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_rsp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
    end
  endtask

  task automatic try_one(input vec_t v, output bit acc);
    req_valid = 1'b1;
    req_we    = v.we;
    req_op    = v.op;
    req_ext   = v.ext;
    req_addr  = BASE + v.off;
    req_wdata = v.wdata;
    @(negedge clk);
    acc = req_ready;
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back('{err: v.err, data: v.rdata});
  endtask

  task automatic send(input vec_t v, output int waited);
    bit acc;
    waited = 0;
    acc    = 1'b0;
    while (!acc && waited <= 200) begin
      try_one(v, acc);
      if (!acc) waited++;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no accept, want accept within 200 cycles");
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int cnt = 0;
    while ((exp_q.size() != 0 || busy) && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check(name, 64'(exp_q.size()), 64'(0));
  endtask

  // Scoreboard: compare the FIFO head whenever it is consumed.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got err=%0b data=0x%h, want no response", rsp_err, rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("rsp%0d", n_rsp), 64'({rsp_err, rsp_rdata}), 64'(e));
        n_rsp++;
      end
    end
  end

  initial begin
    int   w;
    int   lat;
    int   stalls;
    int   k;
    bit   acc;
    vec_t v;

    // Table: {we, op, ext, offset, wdata, exp_err, exp_rdata}
    tbl.push_back('{1'b1, OP_W, 1'b0, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, OP_W, 1'b0, 32'h010, 32'h0,        1'b0, 32'hDEADBEEF});
    tbl.push_back('{1'b1, OP_W, 1'b0, 32'h020, 32'h80FF7F01, 1'b0, 32'h0});
    tbl.push_back('{1'b0, OP_B, 1'b1, 32'h022, 32'h0,        1'b0, 32'hFFFFFFFF});
    tbl.push_back('{1'b0, OP_B, 1'b0, 32'h022, 32'h0,        1'b0, 32'h000000FF});
    tbl.push_back('{1'b0, OP_H, 1'b1, 32'h022, 32'h0,        1'b0, 32'hFFFF80FF});
    tbl.push_back('{1'b0, OP_H, 1'b1, 32'h020, 32'h0,        1'b0, 32'h00007F01});
    tbl.push_back('{1'b0, OP_B, 1'b1, 32'h023, 32'h0,        1'b0, 32'hFFFFFF80});
    tbl.push_back('{1'b0, OP_B, 1'b1, 32'h021, 32'h0,        1'b0, 32'h0000007F});
    tbl.push_back('{1'b0, OP_W, 1'b1, 32'h020, 32'h0,        1'b0, 32'h80FF7F01});
    tbl.push_back('{1'b1, OP_W, 1'b0, 32'h000, 32'h11223344, 1'b0, 32'h0});
    tbl.push_back('{1'b1, OP_W, 1'b0, 32'h004, 32'h55667788, 1'b0, 32'h0});
    tbl.push_back('{1'b0, OP_H, 1'b0, 32'h003, 32'h0,        1'b1, 32'h0});
    tbl.push_back('{1'b0, OP_W, 1'b0, 32'h006, 32'h0,        1'b1, 32'h0});
    tbl.push_back('{1'b1, OP_H, 1'b0, 32'h003, 32'h0000FFFF, 1'b1, 32'h0});
    tbl.push_back('{1'b1, OP_W, 1'b0, 32'h006, 32'hFFFFFFFF, 1'b1, 32'h0});
    tbl.push_back('{1'b0, OP_W, 1'b0, 32'h000, 32'h0,        1'b0, 32'h11223344});
    tbl.push_back('{1'b0, OP_W, 1'b0, 32'h004, 32'h0,        1'b0, 32'h55667788});
    tbl.push_back('{1'b1, OP_W, 1'b0, 32'h1000, 32'hAAAAAAAA, 1'b1, 32'h0});
    tbl.push_back('{1'b0, OP_W, 1'b0, 32'h000, 32'h0,        1'b0, 32'h11223344});
    tbl.push_back('{1'b1, OP_B, 1'b0, 32'h005, 32'h123456EE, 1'b0, 32'h0});
    tbl.push_back('{1'b0, OP_W, 1'b0, 32'h004, 32'h0,        1'b0, 32'h5566EE88});
    tbl.push_back('{1'b1, OP_H, 1'b0, 32'h006, 32'h9999ABCD, 1'b0, 32'h0});
    tbl.push_back('{1'b0, OP_W, 1'b0, 32'h004, 32'h0,        1'b0, 32'hABCDEE88});
    tbl.push_back('{1'b0, OP_R, 1'b0, 32'h004, 32'h0,        1'b1, 32'h0});
    tbl.push_back('{1'b0, OP_W, 1'b0, 32'hFFFFFFFC, 32'h0,   1'b1, 32'h0});
    tbl.push_back('{1'b0, OP_B, 1'b0, 32'h004, 32'h0,        1'b0, 32'h00000088});
    tbl.push_back('{1'b0, OP_H, 1'b1, 32'h004, 32'h0,        1'b0, 32'hFFFFEE88});
    tbl.push_back('{1'b1, OP_W, 1'b0, 32'hFFC, 32'h12345678, 1'b0, 32'h0});
    tbl.push_back('{1'b0, OP_W, 1'b0, 32'hFFC, 32'h0,        1'b0, 32'h12345678});

    bp.push_back('{1'b0, OP_W, 1'b0, 32'h010, 32'h0, 1'b0, 32'hDEADBEEF});
    bp.push_back('{1'b0, OP_W, 1'b0, 32'h020, 32'h0, 1'b0, 32'h80FF7F01});
    bp.push_back('{1'b0, OP_W, 1'b0, 32'h000, 32'h0, 1'b0, 32'h11223344});
    bp.push_back('{1'b0, OP_W, 1'b0, 32'h004, 32'h0, 1'b0, 32'hABCDEE88});
    bp.push_back('{1'b0, OP_W, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'h12345678});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_req_ready", 64'(req_ready), 64'(1));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("reset_rsp_err",   64'(rsp_err),   64'(0));
    check("reset_busy",      64'(busy),      64'(0));

    // Latency of a single load into an empty pipe
    send(tbl[0], w);
    idle();
    drain("drain_store0");
    send(tbl[1], w);
    idle();
    check("busy_inflight", 64'(busy), 64'(1));
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("load_latency", 64'(lat), 64'(LAT));
    drain("drain_latency");

    // Table, back-to-back with rsp_ready high: no stall expected
    stalls = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i], w);
      stalls += w;
    end
    idle();
    drain("drain_table");
    check("table_stalls", 64'(stalls), 64'(0));

    // Backpressure: only RSP_DEPTH loads get in while responses are held
    rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      if (k < 5) begin
        try_one(bp[k], acc);
        if (acc) k++;
      end
    end
    check("bp_accepted",  64'(k),         64'(3));
    check("bp_req_ready", 64'(req_ready), 64'(0));
    check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
    check("bp_busy",      64'(busy),      64'(1));
    rsp_ready = 1'b1;
    while (k < 5) begin
      send(bp[k], w);
      k++;
    end
    idle();
    drain("drain_bp");

    // Reset with responses outstanding; committed store must survive
    v = '{1'b1, OP_W, 1'b0, 32'h030, 32'hCAFEF00D, 1'b0, 32'h0};
    send(v, w);
    idle();
    drain("drain_pre_reset");
    rsp_ready = 1'b0;
    send(bp[0], w);
    send(bp[1], w);
    idle();
    @(posedge clk);
    #1;
    check("pre_reset_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mid_reset_busy",      64'(busy),      64'(0));
    check("mid_reset_req_ready", 64'(req_ready), 64'(1));
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_no_rsp", 64'(rsp_valid), 64'(0));
    v = '{1'b0, OP_W, 1'b0, 32'h030, 32'h0, 1'b0, 32'hCAFEF00D};
    send(v, w);
    idle();
    drain("drain_post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
